// File: rtl/audio_mixer.sv
// rtl/audio_mixer.sv - time-multiplexed CHANNELS-input mixer driving the sigma-delta DAC value input
// Optional sticky clip flag with clip_clr input is enabled by defining AUDIO_MIXER_CLIP_EN.
module audio_mixer #(
  parameter int CHANNELS  = 4,
  parameter int IN_WIDTH  = 8,
  parameter int VOL_WIDTH = 4,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT     = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_tick,
  input  logic [CHANNELS*IN_WIDTH-1:0]  ch_data,
  input  logic [CHANNELS*VOL_WIDTH-1:0] ch_vol,
`ifdef AUDIO_MIXER_CLIP_EN
  input  logic                          clip_clr,
  output logic                          clip,
`endif
  output logic [OUT_WIDTH-1:0]          out_value,
  output logic                          out_valid,
  output logic                          busy
);

  localparam int PROD_W = IN_WIDTH + VOL_WIDTH;
  localparam int ACC_W  = PROD_W + $clog2(CHANNELS);
  localparam int IDX_W  = $clog2(CHANNELS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);
  localparam logic [ACC_W-1:0] OUT_MAX  = ACC_W'({OUT_WIDTH{1'b1}});

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t state;
  state_t next_state;

  logic [IN_WIDTH-1:0]  snap_data [CHANNELS];
  logic [VOL_WIDTH-1:0] snap_vol  [CHANNELS];
  logic [ACC_W-1:0]     acc;
  logic [IDX_W-1:0]     idx;
  logic [PROD_W-1:0]    prod;
  logic [ACC_W-1:0]     shifted;
  logic                 saturate;

  // One shared multiplier, stepped through the snapshot by idx.
  assign prod     = PROD_W'(snap_data[idx]) * PROD_W'(snap_vol[idx]);
  assign shifted  = acc >> SHIFT;
  assign saturate = shifted > OUT_MAX;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (sample_tick) next_state = ACCUM;
      ACCUM:   if (idx == LAST_IDX) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Inputs are frozen at the tick so later changes cannot disturb a mix in flight.
  always_ff @(posedge clk) begin
    if (state == IDLE && sample_tick) begin
      for (int i = 0; i < CHANNELS; i++) begin
        snap_data[i] <= ch_data[i*IN_WIDTH +: IN_WIDTH];
        snap_vol[i]  <= ch_vol[i*VOL_WIDTH +: VOL_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      idx       <= '0;
      out_value <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_tick) begin
            acc <= '0;
            idx <= '0;
          end
        end
        ACCUM: begin
          acc <= acc + ACC_W'(prod);
          idx <= idx + 1'b1;
        end
        DONE: begin
          out_value <= saturate ? {OUT_WIDTH{1'b1}} : shifted[OUT_WIDTH-1:0];
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef AUDIO_MIXER_CLIP_EN
  // A new clip event takes priority over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)                           clip <= 1'b0;
    else if (state == DONE && saturate) clip <= 1'b1;
    else if (clip_clr)                 clip <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_audio_mixer.sv
// tb/tb_audio_mixer.sv - directed table-driven bench for audio_mixer
// Clip checks are compiled only when AUDIO_MIXER_CLIP_EN is defined.
module tb_audio_mixer;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_tick;
  logic [31:0] ch_data;
  logic [15:0] ch_vol;
  logic [7:0]  out_value;
  logic        out_valid;
  logic        busy;
`ifdef AUDIO_MIXER_CLIP_EN
  logic        clip_clr;
  logic        clip;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  audio_mixer dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .ch_data     (ch_data),
    .ch_vol      (ch_vol),
`ifdef AUDIO_MIXER_CLIP_EN
    .clip_clr    (clip_clr),
    .clip        (clip),
`endif
    .out_value   (out_value),
    .out_valid   (out_valid),
    .busy        (busy)
  );

  typedef struct {
    logic [31:0] data;
    logic [15:0] vol;
    logic [7:0]  expect_value;
    string       name;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] model(input logic [31:0] d, input logic [15:0] v);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) s += int'(d[i*8 +: 8]) * int'(v[i*4 +: 4]);
    s = s >> 5;
    if (s > 255) s = 255;
    return s[7:0];
  endfunction

  // Tick sampled at edge T; walks edges T+1..T+12 checking busy, the single valid pulse and the value.
  task automatic run_mix(input logic [31:0] d, input logic [15:0] v, input logic [7:0] expect_value,
                         input string name);
    int valid_count;
    int busy_bad;
    logic [7:0] captured;
    valid_count = 0;
    busy_bad = 0;
    captured = 8'hxx;
    ch_data = d;
    ch_vol = v;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    ch_data = ~d;
    for (int k = 1; k <= 12; k++) begin
      if (busy != (k <= 5)) busy_bad++;
      @(posedge clk); #1;
      if (out_valid) begin
        valid_count++;
        if (k != 5) $display("FAIL %s_latency: got %0d expected 5", name, k);
        if (k != 5) errors++;
        captured = out_value;
      end
    end
    chk({name, "_busy"}, busy_bad, 0);
    chk({name, "_valid_count"}, valid_count, 1);
    chk({name, "_value"}, int'(captured), int'(expect_value));
  endtask

  initial begin
    int valid_count;
    int bad;
    logic [31:0] d;
    logic [15:0] v;
    logic [7:0]  exp_v;

    vecs[0] = '{32'h0000_00C8, 16'h000F, 8'd93,  "single_ch0"};
    vecs[1] = '{32'hFFFF_FFFF, 16'hFFFF, 8'd255, "saturate_all"};
    vecs[2] = '{32'hFFFF_FFFF, 16'h0000, 8'd0,   "all_muted"};
    vecs[3] = '{32'h0000_0064, 16'h0008, 8'd25,  "ch0_vol8"};
    vecs[4] = '{32'h281E_140A, 16'h4321, 8'd9,   "mixed_4ch"};
    vecs[5] = '{32'h00FF_FFFF, 16'h02FF, 8'd255, "exact_full"};
    vecs[6] = '{32'h00FF_FFFF, 16'h03FF, 8'd255, "just_over"};
    vecs[7] = '{32'h2000_0000, 16'h1000, 8'd1,   "last_ch"};
    vecs[8] = '{32'h0000_FF00, 16'h00F0, 8'd119, "ch1_only"};

    rst = 1'b1;
    sample_tick = 1'b0;
    ch_data = '0;
    ch_vol = '0;
`ifdef AUDIO_MIXER_CLIP_EN
    clip_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_out_value", int'(out_value), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_busy", int'(busy), 0);
`ifdef AUDIO_MIXER_CLIP_EN
    chk("reset_clip", int'(clip), 0);
`endif
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (out_value != 8'd0 || out_valid || busy) bad++;
    end
    chk("reset_stable", bad, 0);

    for (int i = 0; i < 9; i++) run_mix(vecs[i].data, vecs[i].vol, vecs[i].expect_value, vecs[i].name);

    // Value must hold while idle.
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_value != 8'd119 || out_valid) bad++;
    end
    chk("hold_idle", bad, 0);

`ifdef AUDIO_MIXER_CLIP_EN
    run_mix(32'hFFFF_FFFF, 16'hFFFF, 8'd255, "clip_sat");
    chk("clip_set", int'(clip), 1);
    repeat (5) @(posedge clk);
    #1 chk("clip_sticky", int'(clip), 1);
    clip_clr = 1'b1;
    @(posedge clk); #1;
    clip_clr = 1'b0;
    chk("clip_cleared", int'(clip), 0);
    run_mix(32'hFFFF_FFFF, 16'h0000, 8'd0, "clip_mute");
    chk("clip_stays_low", int'(clip), 0);
`endif

    // Snapshot + ignored tick while busy.
    ch_data = 32'h0000_0064;
    ch_vol = 16'h0008;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    @(posedge clk); #1;
    ch_data = 32'h0000_00FF;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    valid_count = 0;
    exp_v = 8'hxx;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        valid_count++;
        exp_v = out_value;
      end
    end
    chk("busy_tick_valid_count", valid_count, 1);
    chk("snapshot_value", int'(exp_v), 25);

    // Tick during DONE is dropped.
    ch_data = 32'h0000_00C8;
    ch_vol = 16'h000F;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    repeat (4) @(posedge clk);
    #1 sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    chk("done_tick_valid", int'(out_valid), 1);
    chk("done_tick_value", int'(out_value), 93);
    chk("done_tick_ignored", int'(busy), 0);
    valid_count = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy) valid_count++;
    end
    chk("done_tick_quiet", valid_count, 0);

    // Reset during the third ACCUM cycle.
    ch_data = 32'h0000_00FF;
    ch_vol = 16'h000F;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    valid_count = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) valid_count++;
    end
    chk("midreset_no_valid", valid_count, 0);
    chk("midreset_value", int'(out_value), 0);
    chk("midreset_busy", int'(busy), 0);
    run_mix(32'h0000_00FF, 16'h000F, 8'd119, "after_reset");

    // Back-to-back ticks at the minimum spacing of 6 cycles.
    d = 32'h1234_5678;
    v = 16'h9ABC;
    ch_data = d;
    ch_vol = v;
    sample_tick = 1'b1;
    for (int n = 0; n < 6; n++) begin
      exp_v = model(d, v);
      @(posedge clk); #1;
      sample_tick = 1'b0;
      ch_data = $urandom;
      ch_vol = 16'($urandom);
      bad = 0;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        if (out_valid) bad++;
      end
      @(posedge clk); #1;
      chk($sformatf("b2b_%0d_early_valid", n), bad, 0);
      chk($sformatf("b2b_%0d_valid", n), int'(out_valid), 1);
      chk($sformatf("b2b_%0d_value", n), int'(out_value), int'(exp_v));
      d = $urandom;
      v = 16'($urandom);
      ch_data = d;
      ch_vol = v;
      sample_tick = (n < 5);
    end
    sample_tick = 1'b0;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
